// File: rtl/cpu_isa_pkg.sv
// ISA constants for the 5-stage CPU: group/opcode codes, instruction field positions,
// and the hazard-relevant decode (which register fields an instruction reads/writes).
package cpu_isa_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;

    localparam int GRP_LSB = 16;
    localparam int OP_LSB  = 13;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 4;
    localparam int RD_LSB  = 0;

    localparam logic [2:0] GRP_ARITH  = 3'b000;
    localparam logic [2:0] GRP_LOGIC  = 3'b001;
    localparam logic [2:0] GRP_CTRL   = 3'b010;
    localparam logic [2:0] GRP_MEM    = 3'b011;
    localparam logic [2:0] GRP_CUSTOM = 3'b100;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_INC = 3'd4;
    localparam logic [2:0] OP_DEC = 3'd5;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    localparam logic [2:0] OP_JMP  = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } dec_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_ent_t;

    function automatic dec_t decode(input logic [2:0] grp, input logic [2:0] op);
        dec_t d;
        d = '0;
        case (grp)
            GRP_ARITH: begin
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
                d.writes_rd = 1'b1;
            end
            GRP_LOGIC: begin
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
                d.writes_rd = 1'b1;
            end
            GRP_CTRL: begin
                d.uses_rs1  = (op == OP_JMP) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_CALL);
                d.uses_rs2  = (op == OP_BEQ) || (op == OP_BNE);
                d.writes_rd = (op == OP_CALL);
            end
            GRP_MEM: begin
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = (op == OP_STORE);
                d.writes_rd = (op == OP_LOAD);
            end
            GRP_CUSTOM: begin
                d.uses_rs1  = 1'b1;
                d.writes_rd = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight writer tracking: one slot per cycle until writeback; busy_vec is registered
// state only, so it reflects an issue one cycle later. squash kills the youngest BR_POS slots.
module hazard_scoreboard
    import cpu_isa_pkg::*;
#(
    parameter int WB_LAT = 4,
    parameter int BR_POS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [REG_W-1:0]    wr_rd,
    input  logic                squash,
    output logic [NUM_REGS-1:0] busy_vec
);

    sb_ent_t sb [WB_LAT];

    // squash drops the current youngest entries before they shift, and blocks the shift-in
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < WB_LAT; k++) begin
                sb[k] <= '0;
            end
        end else begin
            sb[0].v  <= wr_en & ~squash;
            sb[0].rd <= wr_rd;
            for (int k = 1; k < WB_LAT; k++) begin
                sb[k].v  <= sb[k-1].v & ~(squash && ((k - 1) < BR_POS));
                sb[k].rd <= sb[k-1].rd;
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int k = 0; k < WB_LAT; k++) begin
            if (sb[k].v) begin
                busy_vec[sb[k].rd] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW stall / taken-branch flush controller beside Fetch->Decode; stall/flush/issue are
// same-cycle combinational, stall holds Fetch until the conflicting writer retires.
module pipeline_hazard_ctrl
    import cpu_isa_pkg::*;
#(
    parameter int WB_LAT    = 4,
    parameter int BR_POS    = 2,
    parameter int FLUSH_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [2:0]          id_group,
    input  logic [2:0]          id_opcode,
    input  logic [3:0]          id_rs1,
    input  logic [3:0]          id_rs2,
    input  logic [3:0]          id_rd,
    input  logic                ex_branch_taken,
    output logic                stall,
    output logic                flush,
    output logic                issue,
    output logic [15:0]         busy_vec,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    dec_t                dec;
    logic [NUM_REGS-1:0] busy;
    logic [FC_W-1:0]     fcnt;
    logic                flush_active;
    logic                hazard;

    assign dec          = decode(id_group, id_opcode);
    assign flush_active = (fcnt != '0);
    assign hazard       = (dec.uses_rs1 & busy[id_rs1]) | (dec.uses_rs2 & busy[id_rs2]);

    // a redirect in flight makes the held instruction wrong-path, so flush overrides stall
    assign stall    = reset & id_valid & ~flush_active & ~ex_branch_taken & hazard;
    assign flush    = reset & (ex_branch_taken | flush_active);
    assign issue    = reset & id_valid & ~stall & ~flush;
    assign busy_vec = reset ? busy : '0;

    hazard_scoreboard #(
        .WB_LAT (WB_LAT),
        .BR_POS (BR_POS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (issue & dec.writes_rd),
        .wr_rd    (id_rd),
        .squash   (ex_branch_taken),
        .busy_vec (busy)
    );

    // a fresh taken branch reloads rather than extends the window
    always_ff @(posedge clk) begin
        if (!reset) begin
            fcnt <= '0;
        end else if (ex_branch_taken) begin
            fcnt <= FC_W'(FLUSH_CYC - 1);
        end else if (flush_active) begin
            fcnt <= fcnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (ex_branch_taken && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed hazard/branch/reset sequences followed by random traffic, checked against a
// pending-write list model; a second 4-bit-counter instance exercises counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int WB_LAT    = 4;
    localparam int BR_POS    = 2;
    localparam int FLUSH_CYC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, id_valid, ex_branch_taken;
    logic [2:0]  id_group, id_opcode;
    logic [3:0]  id_rs1, id_rs2, id_rd;

    logic        stall, flush, issue;
    logic [15:0] busy_vec, stall_count, flush_count;
    logic        s_stall, s_flush, s_issue;
    logic [15:0] s_busy;
    logic [3:0]  s_stall_count, s_flush_count;

    pipeline_hazard_ctrl u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_group(id_group),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .stall(stall), .flush(flush), .issue(issue),
        .busy_vec(busy_vec), .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_group(id_group),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .stall(s_stall), .flush(s_flush), .issue(s_issue),
        .busy_vec(s_busy), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    // reference model: list of issued writers with the cycle they issued
    typedef struct { int rd; int at; } wr_t;
    wr_t pend[$];
    int  cyc        = 0;
    int  flush_end  = 0;
    int  m_stalls   = 0;
    int  m_flushes  = 0;
    bit  last_stall = 0;

    function automatic int sat(input int c, input int w);
        int m;
        m = (1 << w) - 1;
        return (c > m) ? m : c;
    endfunction

    // {reads rs1, reads rs2, writes rd} per group/opcode
    function automatic logic [2:0] ref_decode(input int g, input int op);
        case (g)
            0:       return {1'b1, op < 4, 1'b1};
            1:       return {1'b1, op < 3, 1'b1};
            2:       return {op <= 3, (op == 1) || (op == 2), op == 3};
            3:       return {1'b1, op == 1, op == 0};
            4:       return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] ref_busy();
        logic [15:0] b;
        b = '0;
        foreach (pend[i]) begin
            if ((cyc - pend[i].at >= 1) && (cyc - pend[i].at <= WB_LAT)) b[pend[i].rd] = 1'b1;
        end
        return b;
    endfunction

    task automatic step(input int v, input int g, input int op, input int r1, input int r2,
                        input int rd, input int tk, input int rst);
        logic [2:0]  d;
        logic [15:0] b;
        logic        es, ef, ei;
        wr_t         keep[$];
        @(posedge clk);
        #1;
        reset = rst[0]; id_valid = v[0]; id_group = g[2:0]; id_opcode = op[2:0];
        id_rs1 = r1[3:0]; id_rs2 = r2[3:0]; id_rd = rd[3:0]; ex_branch_taken = tk[0];
        #3;
        d = ref_decode(g, op);
        if (rst == 0) begin
            b = '0; es = 1'b0; ef = 1'b0; ei = 1'b0;
        end else begin
            b  = ref_busy();
            ef = (tk != 0) || (cyc < flush_end);
            es = (v != 0) && !ef && ((d[2] && b[r1]) || (d[1] && b[r2]));
            ei = (v != 0) && !es && !ef;
        end
        check("stall", stall, es);
        check("flush", flush, ef);
        check("issue", issue, ei);
        check("busy_vec", busy_vec, b);
        check("stall_count", stall_count, sat(m_stalls, 16));
        check("flush_count", flush_count, sat(m_flushes, 16));
        check("sat_stall_count", s_stall_count, sat(m_stalls, 4));
        check("sat_flush_count", s_flush_count, sat(m_flushes, 4));
        last_stall = stall;

        if (rst == 0) begin
            pend.delete();
            flush_end = 0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (es) m_stalls++;
            if (tk != 0) begin
                m_flushes++;
                flush_end = cyc + FLUSH_CYC;
                foreach (pend[i]) if (pend[i].at < cyc - BR_POS) keep.push_back(pend[i]);
                pend = keep;
            end
            if (ei && d[0]) pend.push_back('{rd, cyc});
            keep.delete();
            foreach (pend[i]) if (cyc + 1 - pend[i].at <= WB_LAT) keep.push_back(pend[i]);
            pend = keep;
        end
        cyc++;
    endtask

    int nst;
    int v, g, op, r1, r2, rd, tk, rst;

    initial begin
        reset = 1'b0; id_valid = 1'b0; id_group = '0; id_opcode = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_branch_taken = 1'b0;
        @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // RAW: ADD rd=3 then SUB rs1=3 stalls WB_LAT cycles
        step(1, 0, 0, 1, 2, 3, 0, 1);
        nst = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 3, 1, 8, 0, 1);
            if (last_stall) nst++;
        end
        check("raw_stall_cycles", nst, 4);
        check("raw_stall_count", stall_count, 4);

        // no hazard: INC rd=5, NOT rs1=6
        step(1, 0, 4, 1, 1, 5, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 3, 6, 0, 9, 0, 1);

        // rs2-only: STORE rs2=7 after LOAD rd=7; JMP rs2=7 ignores rs2
        step(1, 3, 0, 0, 0, 7, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 3, 1, 0, 7, 0, 0, 1);
        step(1, 3, 0, 0, 0, 7, 0, 1);
        step(1, 2, 0, 0, 7, 0, 0, 1);

        // branch squash, then back-to-back taken during flush
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 2, 0, 1);
        step(1, 0, 0, 0, 0, 4, 0, 1);
        step(1, 0, 1, 2, 0, 1, 1, 1);
        step(1, 0, 1, 2, 0, 1, 0, 1);
        step(1, 0, 1, 2, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 2, 0, 1, 0, 1);

        // reset in the middle of a stall
        step(1, 0, 0, 0, 0, 3, 0, 1);
        step(1, 0, 1, 3, 0, 1, 0, 1);
        step(1, 0, 1, 3, 0, 1, 0, 1);
        step(1, 0, 1, 3, 0, 1, 0, 0);
        step(1, 0, 1, 3, 0, 1, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                g  = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
                op = $urandom_range(0, 7);
                r1 = $urandom_range(0, 3);
                r2 = $urandom_range(0, 3);
                rd = $urandom_range(0, 3);
            end
            tk  = ($urandom_range(0, 11) == 0) ? 1 : 0;
            rst = ($urandom_range(0, 299) == 0) ? 0 : 1;
            step(v, g, op, r1, r2, rd, tk, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
